pcie_rq_ats_merge: RTL and testbench

Merges the ATS Invalidation Completion descriptors from the CQ ATS snooper into the user Requester Request (RQ) AXI-stream ahead of the PCIe hard block. Completions are single-beat descriptors that the snooper emits as one-cycle pulses and does not re-present. This block therefore buffers them in a small FIFO. It interleaves them with user RQ packets using packet-level round-robin arbitration, and it never splits a user packet.

---
 rtl/pcie_rq_ats_merge_if.sv | 25 ++
 rtl/pcie_rq_ats_merge.sv | 130 +++++++++++++
 tb/tb_pcie_rq_ats_merge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_rq_ats_merge_if.sv
// AXI-stream bundle shared by the completion, user RQ and merged streams.
// master drives tdata/tkeep/tuser/tvalid/tlast, slave drives tready.
interface pcie_rq_ats_merge_if #(
  parameter int DW = 512,
  parameter int UW = 137
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (
    output tdata, tkeep, tuser,
    output tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser,
    input  tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/pcie_rq_ats_merge.sv
// Merges buffered ATS invalidation completions into the user RQ stream.
// Ports: clk, rst_n, s_inv/s_usr (slave), m_axis (master), level, drops.
module pcie_rq_ats_merge #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int RQ_TUSER_WIDTH  = 137,
  parameter int INV_FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  pcie_rq_ats_merge_if.slave  s_inv,
  pcie_rq_ats_merge_if.slave  s_usr,
  pcie_rq_ats_merge_if.master m_axis,
  output logic [$clog2(INV_FIFO_DEPTH):0] inv_fifo_level,
  output logic [15:0] inv_drop_cnt
);

  localparam int DW = AXIS_DATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int AW = $clog2(INV_FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(INV_FIFO_DEPTH);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE,
    USR,
    INV
  } st_e;

  ent_t        mem_q [INV_FIFO_DEPTH];
  ent_t        head;
  logic [AW:0] wptr_q, rptr_q;
  logic        full, empty;
  logic        push, pop, drop;
  st_e         st_q, st_d;
  logic        lg_inv_q, lg_inv_d;
  logic        sel_usr, sel_inv;
  logic        mv, hs;
  logic        unused_inv;

  assign unused_inv = ^{s_inv.tuser, s_inv.tlast};

  assign inv_fifo_level = wptr_q - rptr_q;
  assign full  = inv_fifo_level == DEPTH;
  assign empty = wptr_q == rptr_q;
  assign head  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle never frees a slot for a full-FIFO push.
  assign s_inv.tready = rst_n && !full;
  assign push = s_inv.tvalid && s_inv.tready;
  assign drop = rst_n && s_inv.tvalid && full;

  always_comb begin
    st_d     = st_q;
    lg_inv_d = lg_inv_q;
    sel_usr  = 1'b0;
    sel_inv  = 1'b0;
    pop      = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (s_usr.tvalid && !empty) begin
          sel_inv = !lg_inv_q;
          sel_usr = lg_inv_q;
        end else begin
          sel_usr = s_usr.tvalid;
          sel_inv = !empty;
        end
      end
      USR:     sel_usr = 1'b1;
      INV:     sel_inv = 1'b1;
      default: ;
    endcase

    mv = rst_n && (sel_usr ? s_usr.tvalid : sel_inv);
    hs = mv && m_axis.tready;

    // Without a handshake the selection is locked so the beat stays put.
    if (sel_inv) begin
      if (hs) begin
        pop      = 1'b1;
        lg_inv_d = 1'b1;
        st_d     = IDLE;
      end else begin
        st_d = INV;
      end
    end
    if (sel_usr) begin
      if (hs) begin
        lg_inv_d = 1'b0;
        st_d     = s_usr.tlast ? IDLE : USR;
      end else begin
        st_d = USR;
      end
    end

    m_axis.tvalid = mv;
    m_axis.tdata  = sel_inv ? head.d : s_usr.tdata;
    m_axis.tkeep  = sel_inv ? head.k : s_usr.tkeep;
    m_axis.tuser  = sel_inv ? '0 : s_usr.tuser;
    m_axis.tlast  = sel_inv ? 1'b1 : s_usr.tlast;
    s_usr.tready  = rst_n && sel_usr && m_axis.tready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= IDLE;
      lg_inv_q     <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      inv_drop_cnt <= '0;
    end else begin
      st_q     <= st_d;
      lg_inv_q <= lg_inv_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (drop && inv_drop_cnt != 16'hFFFF)
        inv_drop_cnt <= inv_drop_cnt + 1'b1;
    end
  end

  // Payload storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q[AW-1:0]] <= '{d: s_inv.tdata, k: s_inv.tkeep};
  end

endmodule

// File: tb/tb_pcie_rq_ats_merge.sv
// Randomized and directed bench for pcie_rq_ats_merge.
// Checks the merged stream against a queue-based reference model.
module tb_pcie_rq_ats_merge;

  localparam int DW = 512;
  localparam int UW = 137;
  localparam int KW = DW / 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_rq_ats_merge_if #(.DW(DW), .UW(UW)) s_inv_if ();
  pcie_rq_ats_merge_if #(.DW(DW), .UW(UW)) s_usr_if ();
  pcie_rq_ats_merge_if #(.DW(DW), .UW(UW)) m_if ();

  logic [LW-1:0] inv_fifo_level;
  logic [15:0]   inv_drop_cnt;

  pcie_rq_ats_merge #(
    .AXIS_DATA_WIDTH(DW),
    .RQ_TUSER_WIDTH(UW),
    .INV_FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_inv(s_inv_if),
    .s_usr(s_usr_if),
    .m_axis(m_if),
    .inv_fifo_level(inv_fifo_level),
    .inv_drop_cnt(inv_drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t usr_src[$];
  beat_t usr_exp[$];
  beat_t inv_q[$];
  bit    out_log[$];

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int drops  = 0;
  int inv_out = 0;
  bit usr_hold = 0;
  bit in_pkt = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_d;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [KW-1:0] rnd_k();
    return {$urandom, $urandom};
  endfunction

  function automatic beat_t mk_usr(input bit last);
    beat_t b;
    b.d = rnd_d();
    b.k = rnd_k();
    b.u = UW'({$urandom, $urandom, $urandom, $urandom, $urandom});
    b.u[0] = 1'b1;
    b.l = last;
    return b;
  endfunction

  function automatic beat_t mk_inv();
    beat_t b;
    b.d = rnd_d();
    b.k = rnd_k();
    b.u = '0;
    b.l = 1'b1;
    return b;
  endfunction

  task automatic add_pkt(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = mk_usr(i == n - 1);
      usr_src.push_back(b);
      usr_exp.push_back(b);
    end
  endtask

  task automatic chk_log(input string tag, input int n,
                         input logic [15:0] pat);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < out_log.size() && i < 16; i++)
      o[i] = out_log[i];
    chk({tag, "_len"}, out_log.size(), n);
    chk({tag, "_ord"}, o, pat);
  endtask

  // One clock: drive at posedge+1, check and update model at negedge.
  task automatic step(input bit inv_v, input beat_t ib,
                      input bit rdy, input bit usr_en);
    bit full;
    bit uacc;
    beat_t e;
    s_inv_if.tvalid = inv_v;
    s_inv_if.tdata  = ib.d;
    s_inv_if.tkeep  = ib.k;
    m_if.tready     = rdy;
    if (usr_src.size() > 0) begin
      s_usr_if.tdata  = usr_src[0].d;
      s_usr_if.tkeep  = usr_src[0].k;
      s_usr_if.tuser  = usr_src[0].u;
      s_usr_if.tlast  = usr_src[0].l;
      s_usr_if.tvalid = usr_hold || usr_en;
    end else begin
      s_usr_if.tvalid = 1'b0;
      s_usr_if.tlast  = 1'b0;
    end
    @(negedge clk);
    full = inv_q.size() == D;
    chk("level", inv_fifo_level, inv_q.size());
    chk("drops", inv_drop_cnt, drops);
    chk("inv_rdy", s_inv_if.tready, !full);
    if (prev_stall) begin
      chk("hold_v", m_if.tvalid, 1);
      chk("hold_d", m_if.tdata, prev_d);
    end
    uacc = s_usr_if.tvalid && s_usr_if.tready;
    if (m_if.tvalid && m_if.tready) begin
      if (m_if.tuser[0]) begin
        out_log.push_back(1'b0);
        chk("usr_rdy", uacc, 1);
        chk("usr_avail", usr_exp.size() > 0, 1);
        if (usr_exp.size() > 0) begin
          e = usr_exp.pop_front();
          chk("usr_d", m_if.tdata, e.d);
          chk("usr_k", m_if.tkeep, e.k);
          chk("usr_u", m_if.tuser, e.u);
          chk("usr_l", m_if.tlast, e.l);
        end
        in_pkt = !m_if.tlast;
      end else begin
        out_log.push_back(1'b1);
        inv_out++;
        chk("contig", in_pkt, 0);
        chk("inv_avail", inv_q.size() > 0, 1);
        if (inv_q.size() > 0) begin
          e = inv_q.pop_front();
          chk("inv_d", m_if.tdata, e.d);
          chk("inv_k", m_if.tkeep, e.k);
        end
        chk("inv_l", m_if.tlast, 1);
        chk("inv_u", m_if.tuser, 0);
      end
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_d = m_if.tdata;
    if (s_inv_if.tvalid) begin
      if (full) begin
        if (drops < 16'hFFFF) drops++;
      end else begin
        inv_q.push_back(ib);
      end
    end
    @(posedge clk);
    #1;
    if (uacc) void'(usr_src.pop_front());
    usr_hold = s_usr_if.tvalid && !uacc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    beat_t x;
    beat_t ib;
    int n0;
    x = mk_inv();
    s_inv_if.tuser = '0;
    s_inv_if.tlast = 1'b1;
    s_inv_if.tdata = '0;
    s_inv_if.tkeep = '0;
    s_usr_if.tdata = '0;
    s_usr_if.tkeep = '0;
    s_usr_if.tuser = '1;
    s_usr_if.tlast = 1'b0;

    // Reset with both sources requesting
    rst_n = 1'b0;
    s_inv_if.tvalid = 1'b1;
    s_usr_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_usr_rdy", s_usr_if.tready, 0);
    chk("rst_inv_rdy", s_inv_if.tready, 0);
    s_inv_if.tvalid = 1'b0;
    s_usr_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_level", inv_fifo_level, 0);
    chk("rst_drops", inv_drop_cnt, 0);
    @(posedge clk);
    #1;

    // Lone INV, tag 5A, out one cycle after push
    ib = mk_inv();
    ib.d[103:96] = 8'h5A;
    n0 = inv_out;
    step(1, ib, 1, 0);
    chk("lone_n", inv_out - n0, 0);
    step(0, x, 1, 0);
    chk("lone_n1", inv_out - n0, 1);
    step(0, x, 1, 0);
    chk("lone_lvl", inv_fifo_level, 0);

    // INV arrives during a 4-beat user packet
    out_log.delete();
    add_pkt(4);
    step(0, x, 1, 1);
    step(1, mk_inv(), 1, 1);
    repeat (4) step(0, x, 1, 1);
    chk_log("t_midpkt", 5, 16'h0010);

    // Stalled user beat must not be preempted
    out_log.delete();
    add_pkt(1);
    step(0, x, 0, 1);
    step(1, mk_inv(), 0, 1);
    repeat (2) step(0, x, 0, 1);
    repeat (3) step(0, x, 1, 0);
    chk_log("t_stall", 2, 16'h0002);

    // Overflow: 6 pulses into a 4-entry FIFO
    for (int i = 0; i < 6; i++) step(1, mk_inv(), 0, 0);
    step(0, x, 0, 0);
    chk("ovf_lvl", inv_fifo_level, 4);
    chk("ovf_drop", inv_drop_cnt, 2);
    chk("ovf_rdy", s_inv_if.tready, 0);
    out_log.delete();
    repeat (6) step(0, x, 1, 0);
    chk_log("t_ovf", 4, 16'h000F);

    // Round-robin: 3 INV queued, three 2-beat user packets
    out_log.delete();
    for (int i = 0; i < 3; i++) step(1, mk_inv(), 0, 0);
    for (int i = 0; i < 3; i++) add_pkt(2);
    repeat (12) step(0, x, 1, 1);
    chk_log("t_rr", 9, 16'h0049);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (usr_src.size() == 0 && $urandom_range(0, 2) == 0)
        add_pkt($urandom_range(1, 4));
      step($urandom_range(0, 9) < 3, mk_inv(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 200 && (usr_src.size() > 0 || inv_q.size() > 0); i++)
      step(0, x, 1, 1);
    step(0, x, 1, 1);
    chk("drain_usr", usr_exp.size(), 0);
    chk("drain_inv", inv_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
